// File: rtl/bp_pkg.sv
// Shared definitions for the dynamic branch predictor: PC source encoding
// and saturating-counter helpers used by the counter table.
package bp_pkg;

  // Next-PC source select driven towards Fetch.
  localparam logic [1:0] PCSRC_INC    = 2'b00;  // pc + 4
  localparam logic [1:0] PCSRC_TGT_D  = 2'b01;  // predicted-taken target from Decode
  localparam logic [1:0] PCSRC_FALL_E = 2'b10;  // recovery: pc_E + 4
  localparam logic [1:0] PCSRC_TGT_E  = 2'b11;  // recovery: Execute target

  // Saturating step of a `bits`-wide counter; holds at 0 and at all-ones.
  function automatic int ctr_next(input int ctr, input logic taken, input int bits);
    int top;
    top = (1 << bits) - 1;
    if (taken) return (ctr >= top) ? top : ctr + 1;
    else       return (ctr <= 0)   ? 0   : ctr - 1;
  endfunction

  // Weakly not-taken: the largest value whose MSB is still clear.
  function automatic int weak_nt(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

endpackage

// File: rtl/sat_counter_table.sv
// ENTRIES x CTR_BITS saturating counter array. One combinational read port
// for Decode lookups, one read-modify-write update port for Execute.
// No write-to-read bypass: a same-cycle lookup sees the old value.
module sat_counter_table
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int IDX_W    = $clog2(ENTRIES)
)(
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_W-1:0]    i_rd_idx,
  output logic [CTR_BITS-1:0] o_rd_ctr,
  input  logic                i_upd_en,
  input  logic [IDX_W-1:0]    i_upd_idx,
  input  logic                i_upd_taken
);

  logic [ENTRIES-1:0][CTR_BITS-1:0] r_ctr;
  logic [CTR_BITS-1:0]              w_upd_nxt;
  logic [CTR_BITS-1:0]              w_rst_val;

  assign o_rd_ctr  = r_ctr[i_rd_idx];
  assign w_upd_nxt = CTR_BITS'(ctr_next(int'(r_ctr[i_upd_idx]), i_upd_taken, CTR_BITS));
  assign w_rst_val = CTR_BITS'(weak_nt(CTR_BITS));

  // Reset every entry to weakly not-taken; otherwise apply the resolved outcome.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= w_rst_val;
    end else if (i_upd_en) begin
      r_ctr[i_upd_idx] <= w_upd_nxt;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor (bimodal, or gshare when GHR_BITS > 0).
// Predicts in Decode, trains and detects mispredictions in Execute, and
// selects the next PC source including the redirect-to-target recovery.
module branch_predictor
  import bp_pkg::*;
#(
  parameter  int PC_W     = 32,
  parameter  int ENTRIES  = 64,
  parameter  int CTR_BITS = 2,
  parameter  int GHR_BITS = 0,
  parameter  int STAT_W   = 32,
  localparam int IDX_W    = $clog2(ENTRIES)
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   pc_D,
  input  logic              branch_D,
  input  logic              jump_D,
  output logic              predict_taken_D,
  output logic [IDX_W-1:0]  index_D,
  input  logic              branch_E,
  input  logic              stall_E,
  input  logic              predicted_E,
  input  logic [IDX_W-1:0]  index_E,
  input  logic              taken_E,
  output logic              mispredict_E,
  output logic [1:0]        PCSrcE,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  logic [IDX_W-1:0]    w_pc_idx;
  logic [IDX_W-1:0]    w_ghr_ext;
  logic [CTR_BITS-1:0] w_rd_ctr;
  logic                w_valid_E;
  logic                w_unused_pc;
  logic [STAT_W-1:0]   r_branch_count;
  logic [STAT_W-1:0]   r_mispredict_count;

  // Word-aligned PC bits select the entry; the rest of the PC is ignored.
  assign w_pc_idx    = pc_D[IDX_W+1:2];
  assign w_unused_pc = ^{pc_D[PC_W-1:IDX_W+2], pc_D[1:0]};

  // History register only exists for gshare; bimodal folds in zero.
  generate
    if (GHR_BITS == 0) begin : g_bimodal
      assign w_ghr_ext = '0;
    end else begin : g_gshare
      logic [GHR_BITS-1:0] r_ghr;

      // Non-speculative history: shift resolved outcomes in at the LSB.
      always_ff @(posedge clk) begin
        if (reset)          r_ghr <= '0;
        else if (w_valid_E) r_ghr <= GHR_BITS'({r_ghr, taken_E});
      end

      // Zero-extend the history onto the low index bits.
      always_comb begin
        w_ghr_ext                 = '0;
        w_ghr_ext[GHR_BITS-1:0]   = r_ghr;
      end
    end
  endgenerate

  assign index_D = w_pc_idx ^ w_ghr_ext;

  sat_counter_table #(
    .ENTRIES  (ENTRIES),
    .CTR_BITS (CTR_BITS),
    .IDX_W    (IDX_W)
  ) u_table (
    .clk         (clk),
    .reset       (reset),
    .i_rd_idx    (index_D),
    .o_rd_ctr    (w_rd_ctr),
    .i_upd_en    (w_valid_E),
    .i_upd_idx   (index_E),
    .i_upd_taken (taken_E)
  );

  assign predict_taken_D = jump_D | (branch_D & w_rd_ctr[CTR_BITS-1]);

  // A stalled Execute neither trains nor redirects; it resolves on release.
  assign w_valid_E    = branch_E & ~stall_E;
  assign mispredict_E = w_valid_E & (taken_E != predicted_E);

  // Execute recovery beats any Decode redirect in the same cycle.
  always_comb begin
    PCSrcE = PCSRC_INC;
    if (mispredict_E)         PCSrcE = taken_E ? PCSRC_TGT_E : PCSRC_FALL_E;
    else if (predict_taken_D) PCSrcE = PCSRC_TGT_D;
  end

  // Saturating statistics over resolved (non-stalled) branches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (w_valid_E) begin
      if (r_branch_count != {STAT_W{1'b1}})
        r_branch_count <= r_branch_count + STAT_W'(1);
      if (mispredict_E && (r_mispredict_count != {STAT_W{1'b1}}))
        r_mispredict_count <= r_mispredict_count + STAT_W'(1);
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a bimodal and a 4-bit gshare instance share
// stimulus; a table of directed vectors, a few hand sequences and a random
// run are checked against an array-based reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_D;
  logic        branch_D, jump_D, branch_E, stall_E, predicted_E, taken_E;
  logic [5:0]  index_E;

  logic        b_pred, g_pred, b_misp, g_misp;
  logic [5:0]  b_idx, g_idx;
  logic [1:0]  b_src, g_src;
  logic [31:0] b_bc, b_mc, g_bc, g_mc;

  always #5 clk = ~clk;

  branch_predictor u_bim (
    .clk(clk), .reset(reset), .pc_D(pc_D), .branch_D(branch_D), .jump_D(jump_D),
    .predict_taken_D(b_pred), .index_D(b_idx), .branch_E(branch_E), .stall_E(stall_E),
    .predicted_E(predicted_E), .index_E(index_E), .taken_E(taken_E),
    .mispredict_E(b_misp), .PCSrcE(b_src), .branch_count(b_bc), .mispredict_count(b_mc)
  );

  branch_predictor #(.GHR_BITS(4)) u_gsh (
    .clk(clk), .reset(reset), .pc_D(pc_D), .branch_D(branch_D), .jump_D(jump_D),
    .predict_taken_D(g_pred), .index_D(g_idx), .branch_E(branch_E), .stall_E(stall_E),
    .predicted_E(predicted_E), .index_E(index_E), .taken_E(taken_E),
    .mispredict_E(g_misp), .PCSrcE(g_src), .branch_count(g_bc), .mispredict_count(g_mc)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: counter values as plain integers, history as an int.
  int mb[64];
  int mg[64];
  int ghr;
  int m_bc, m_mc;

  typedef struct {
    logic [31:0] pc;
    bit br, jp, bE, sE, pE;
    int iE;
    bit tE;
    bit ep;
    int es;
    bit em;
    int ebc, emc;
  } vec_t;

  vec_t tv[15];

  function automatic vec_t mk(input logic [31:0] pc, input bit br, jp, bE, sE, pE,
                              input int iE, input bit tE, ep, input int es,
                              input bit em, input int ebc, emc);
    vec_t v;
    v.pc = pc; v.br = br; v.jp = jp; v.bE = bE; v.sE = sE; v.pE = pE;
    v.iE = iE; v.tE = tE; v.ep = ep; v.es = es; v.em = em; v.ebc = ebc; v.emc = emc;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin mb[i] = 1; mg[i] = 1; end
    ghr = 0; m_bc = 0; m_mc = 0;
  endtask

  function automatic bit m_pred(input int c);
    return jump_D || (branch_D && c >= 2);
  endfunction

  function automatic int m_src(input bit misp, input bit pred);
    if (misp) return taken_E ? 3 : 2;
    return pred ? 1 : 0;
  endfunction

  // Compare every output of both instances against the model.
  task automatic check_all();
    int ib, ig;
    bit vE, mp, pb, pg;
    ib = int'(pc_D >> 2) % 64;
    ig = ib ^ ghr;
    vE = branch_E && !stall_E;
    mp = vE && (taken_E != predicted_E);
    pb = m_pred(mb[ib]);
    pg = m_pred(mg[ig]);
    cmp("bim_index", b_idx, ib);
    cmp("gsh_index", g_idx, ig);
    cmp("bim_pred", b_pred, pb);
    cmp("gsh_pred", g_pred, pg);
    cmp("bim_misp", b_misp, mp);
    cmp("gsh_misp", g_misp, mp);
    cmp("bim_pcsrc", b_src, m_src(mp, pb));
    cmp("gsh_pcsrc", g_src, m_src(mp, pg));
    cmp("bim_bcount", b_bc, m_bc);
    cmp("bim_mcount", b_mc, m_mc);
    cmp("gsh_bcount", g_bc, m_bc);
    cmp("gsh_mcount", g_mc, m_mc);
  endtask

  // Effect of the clock edge on the model, using the inputs held across it.
  task automatic model_update();
    bit vE;
    vE = branch_E && !stall_E;
    if (reset) model_reset();
    else if (vE) begin
      if (taken_E) begin
        mb[index_E] = (mb[index_E] < 3) ? mb[index_E] + 1 : 3;
        mg[index_E] = (mg[index_E] < 3) ? mg[index_E] + 1 : 3;
      end else begin
        mb[index_E] = (mb[index_E] > 0) ? mb[index_E] - 1 : 0;
        mg[index_E] = (mg[index_E] > 0) ? mg[index_E] - 1 : 0;
      end
      ghr = ((ghr << 1) | int'(taken_E)) & 15;
      m_bc++;
      if (taken_E != predicted_E) m_mc++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; pc_D = 0; branch_D = 0; jump_D = 0; branch_E = 0;
    stall_E = 0; predicted_E = 0; index_E = 0; taken_E = 0;
  endtask

  initial begin
    bit seq[4];

    // Bimodal directed vectors, applied in order from a fresh reset.
    tv[0]  = mk(32'h100, 1, 0, 0, 0, 0, 'h00, 0, 0, 0, 0, 0, 0);
    tv[1]  = mk(32'h100, 0, 1, 0, 0, 0, 'h00, 0, 1, 1, 0, 0, 0);
    tv[2]  = mk(32'h040, 1, 0, 1, 0, 0, 'h10, 1, 0, 3, 1, 0, 0);
    tv[3]  = mk(32'h040, 1, 0, 1, 0, 0, 'h10, 1, 1, 3, 1, 1, 1);
    tv[4]  = mk(32'h040, 1, 0, 0, 0, 0, 'h00, 0, 1, 1, 0, 2, 2);
    for (int k = 0; k < 5; k++)
      tv[5+k] = mk(32'h040, 1, 0, 1, 0, 1, 'h10, 1, 1, 1, 0, 2 + k, 2);
    tv[10] = mk(32'h200, 0, 1, 1, 0, 1, 'h20, 0, 1, 2, 1, 7, 2);
    tv[11] = mk(32'h0C0, 1, 0, 1, 1, 0, 'h30, 1, 0, 0, 0, 8, 3);
    tv[12] = mk(32'h0C0, 1, 0, 1, 0, 0, 'h30, 1, 0, 3, 1, 8, 3);
    tv[13] = mk(32'h0C0, 1, 0, 0, 0, 0, 'h00, 0, 1, 1, 0, 9, 4);
    tv[14] = mk(32'h080, 1, 0, 0, 0, 0, 'h00, 0, 0, 0, 0, 9, 4);

    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 0;

    foreach (tv[i]) begin
      pc_D = tv[i].pc; branch_D = tv[i].br; jump_D = tv[i].jp;
      branch_E = tv[i].bE; stall_E = tv[i].sE; predicted_E = tv[i].pE;
      index_E = 6'(tv[i].iE); taken_E = tv[i].tE;
      @(negedge clk);
      cmp($sformatf("vec%0d_pred", i), b_pred, tv[i].ep);
      cmp($sformatf("vec%0d_pcsrc", i), b_src, tv[i].es);
      cmp($sformatf("vec%0d_misp", i), b_misp, tv[i].em);
      cmp($sformatf("vec%0d_bcount", i), b_bc, tv[i].ebc);
      cmp($sformatf("vec%0d_mcount", i), b_mc, tv[i].emc);
      check_all();
      @(posedge clk);
      model_update();
      #1;
    end

    // Gshare history: resolve T,T,N,T from reset, then look up pc 0xC.
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
    seq = '{1, 1, 0, 1};
    foreach (seq[i]) begin
      branch_E = 1; index_E = 6'd5; taken_E = seq[i]; predicted_E = 0;
      step();
    end
    idle_inputs();
    pc_D = 32'hC; branch_D = 1;
    @(negedge clk);
    cmp("ghr_gsh_index", g_idx, 6'hE);
    cmp("ghr_bim_index", b_idx, 6'h3);
    cmp("ghr_bcount", g_bc, 4);
    cmp("ghr_mcount", g_mc, 3);
    step();

    // Reset with an update pending: the update must be dropped.
    reset = 1; branch_E = 1; taken_E = 1; predicted_E = 0; index_E = 6'hE;
    step();
    idle_inputs();
    pc_D = 32'hC; branch_D = 1;
    @(negedge clk);
    cmp("rst_gsh_index", g_idx, 6'h3);
    cmp("rst_bcount", g_bc, 0);
    cmp("rst_mcount", g_mc, 0);
    for (int i = 0; i < 64; i++) begin
      pc_D = 32'(i << 2); branch_D = 1;
      @(negedge clk);
      cmp($sformatf("rst_entry%0d_pred", i), g_pred, 0);
      step();
    end

    // Random traffic concentrated on a few entries so counters saturate.
    for (int n = 0; n < 500; n++) begin
      reset       = ($urandom_range(63) == 0);
      pc_D        = $urandom();
      if ($urandom_range(3) != 0) pc_D[7:2] = 6'($urandom_range(7));
      branch_D    = $urandom_range(1);
      jump_D      = ($urandom_range(4) == 0);
      branch_E    = $urandom_range(1);
      stall_E     = ($urandom_range(3) == 0);
      predicted_E = $urandom_range(1);
      taken_E     = $urandom_range(1);
      index_E     = ($urandom_range(3) != 0) ? 6'($urandom_range(7)) : 6'($urandom_range(63));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
